// File: rtl/mac_lane_feeder.sv
// Sequences one MAC-lane job: clears the lane, streams vector pairs, waits out the lane latency, pulses done.
// Latency: beat on bus 1 cycle after handshake; done LANE_LAT cycles after last bus beat. Backpressure: in_ready only in STREAM.
module mac_lane_feeder #(
  parameter int IL       = 4,
  parameter int FL       = 16,
  parameter int LW       = 8,
  parameter int CLR_CYC  = 2,
  parameter int LANE_LAT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LW-1:0]          cmd_len,
  input  logic                   cmd_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*(IL+FL)-1:0]  in_i,
  input  logic [16*(IL+FL)-1:0]  in_w,
  output logic [16*(IL+FL)-1:0]  i_bus,
  output logic [16*(IL+FL)-1:0]  w_bus,
  output logic                   lane_clr,
  output logic                   lane_mode,
  output logic                   busy,
  output logic                   done
);

  localparam int VW = 16 * (IL + FL);
  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int DW = (LANE_LAT > 1) ? $clog2(LANE_LAT) : 1;

  localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_CYC - 1);
  localparam logic [DW-1:0] DRN_LOAD   = DW'(LANE_LAT - 1);
  // A zero-length job has no final bus beat, so its drain is one cycle shorter.
  localparam logic [DW-1:0] DRN_LOAD_Z = DW'((LANE_LAT > 1) ? LANE_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DW-1:0]   drn_cnt_q, drn_cnt_d;
  logic [VW-1:0]   i_bus_q, i_bus_d;
  logic [VW-1:0]   w_bus_q, w_bus_d;
  logic            lane_clr_q, lane_clr_d;
  logic            lane_mode_q, lane_mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            beat_hs;

  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_STREAM);
  assign beat_hs   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    clr_cnt_d = clr_cnt_q;
    drn_cnt_d = drn_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_CLEAR;
          beat_d    = cmd_len;
          clr_cnt_d = CLR_LOAD;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q != '0) begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end else if (beat_q != '0) begin
          state_d = S_STREAM;
        end else if (LANE_LAT > 1) begin
          state_d   = S_DRAIN;
          drn_cnt_d = DRN_LOAD_Z;
        end else begin
          state_d = S_DONE;
        end
      end
      S_STREAM: begin
        if (beat_hs) begin
          beat_d = beat_q - 1'b1;
          if (beat_q == LW'(1)) begin
            state_d   = S_DRAIN;
            drn_cnt_d = DRN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (drn_cnt_q != '0) begin
          drn_cnt_d = drn_cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decode the next state so they line up with the state they describe.
  always_comb begin
    lane_clr_d  = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    lane_mode_d = lane_mode_q;
    if ((state_q == S_IDLE) && cmd_valid) begin
      lane_mode_d = cmd_mode;
    end
    i_bus_d = '0;
    w_bus_d = '0;
    if (beat_hs) begin
      i_bus_d = in_i;
      w_bus_d = in_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q      <= '0;
      clr_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      i_bus_q     <= '0;
      w_bus_q     <= '0;
      lane_clr_q  <= 1'b1;
      lane_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      clr_cnt_q   <= clr_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      i_bus_q     <= i_bus_d;
      w_bus_q     <= w_bus_d;
      lane_clr_q  <= lane_clr_d;
      lane_mode_q <= lane_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign i_bus     = i_bus_q;
  assign w_bus     = w_bus_q;
  assign lane_clr  = lane_clr_q;
  assign lane_mode = lane_mode_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_lane_feeder.sv
// Directed bench for mac_lane_feeder: table of jobs with hand-computed timing and lane results,
// plus hand sequences for reset values and reset mid-stream.
module tb_mac_lane_feeder;

  localparam int IL       = 4;
  localparam int FL       = 16;
  localparam int LW       = 8;
  localparam int CLR_CYC  = 2;
  localparam int LANE_LAT = 8;
  localparam int EW       = IL + FL;
  localparam int VW       = 16 * EW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          cmd_mode;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_i;
  logic [VW-1:0] in_w;
  logic [VW-1:0] i_bus;
  logic [VW-1:0] w_bus;
  logic          lane_clr;
  logic          lane_mode;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mac_lane_feeder #(
    .IL(IL), .FL(FL), .LW(LW), .CLR_CYC(CLR_CYC), .LANE_LAT(LANE_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_w(in_w),
    .i_bus(i_bus), .w_bus(w_bus), .lane_clr(lane_clr), .lane_mode(lane_mode),
    .busy(busy), .done(done)
  );

  typedef struct {
    string           name;
    int              len;
    bit              mode;
    logic [7:0]      vpat;      // in_valid per STREAM cycle, bit 0 first
    int              npat;      // pattern length; in_valid=1 afterwards
    logic [EW-1:0]   ival;
    logic [EW-1:0]   wval;
    bit              rej;       // present a competing command in the first STREAM cycle
    int              exp_done;  // cycle of done, counted from the accept edge
    int              exp_bus;   // nonzero bus cycles
    longint unsigned exp_f;     // lane result in the done cycle
  } job_t;

  job_t vec[5];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input string name, input int len, input bit mode, input logic [7:0] vpat,
                              input int npat, input logic [EW-1:0] ival, input logic [EW-1:0] wval,
                              input bit rej, input int exp_done, input int exp_bus,
                              input longint unsigned exp_f);
    job_t j;
    j.name = name; j.len = len; j.mode = mode; j.vpat = vpat; j.npat = npat;
    j.ival = ival; j.wval = wval; j.rej = rej; j.exp_done = exp_done;
    j.exp_bus = exp_bus; j.exp_f = exp_f;
    return j;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [EW-1:0] e);
    logic [VW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*EW +: EW] = e;
    return v;
  endfunction

  // Reference lane: sum of per-element fixed-point products, positive operands only.
  function automatic longint unsigned dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint unsigned s, ea, eb;
    s = 0;
    for (int k = 0; k < 16; k++) begin
      ea = 64'(a[k*EW +: EW]);
      eb = 64'(b[k*EW +: EW]);
      s += (ea * eb) >> FL;
    end
    return s;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_job(input job_t j);
    int t, idx, hs_cnt, clr_cnt, clr_first, bus_cyc, bus_bad, mode_bad, busy_bad, done_t;
    bit prev_hs, hs;
    longint unsigned acc;
    logic [VW-1:0] vi, vw;
    vi = splat(j.ival);
    vw = splat(j.wval);
    check({j.name, "/idle_busy"}, 64'(busy), 64'd0);
    check({j.name, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_len = LW'(j.len); cmd_mode = j.mode;
    in_valid = 1'b0; in_i = vi; in_w = vw;
    idx = 0; hs_cnt = 0; clr_cnt = 0; clr_first = -1; bus_cyc = 0; bus_bad = 0;
    mode_bad = 0; busy_bad = 0; done_t = -1; prev_hs = 1'b0; acc = 0;
    for (t = 1; t <= 600 && done_t < 0; t++) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (lane_clr) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = t;
        acc = 0;
      end else begin
        acc += dot(i_bus, w_bus);
      end
      if (i_bus !== (prev_hs ? vi : '0) || w_bus !== (prev_hs ? vw : '0)) bus_bad++;
      if (i_bus != '0) bus_cyc++;
      if (lane_mode !== j.mode) mode_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_t = t;
        check({j.name, "/lane_f"}, acc, j.exp_f);
      end
      hs = 1'b0;
      if (in_ready) begin
        in_valid = (idx < j.npat) ? j.vpat[idx] : 1'b1;
        idx++;
        if (j.rej && idx == 1) begin
          cmd_valid = 1'b1;
          cmd_len   = LW'(3);
          check({j.name, "/busy_cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        hs = in_valid;
      end else begin
        in_valid = 1'b1;
      end
      if (hs) hs_cnt++;
      prev_hs = hs;
    end
    in_valid = 1'b0;
    check({j.name, "/clr_cycles"}, 64'(clr_cnt), 64'(CLR_CYC));
    check({j.name, "/clr_first"}, 64'(clr_first), 64'd1);
    check({j.name, "/handshakes"}, 64'(hs_cnt), 64'(j.len));
    check({j.name, "/bus_data"}, 64'(bus_bad), 64'd0);
    check({j.name, "/bus_cycles"}, 64'(bus_cyc), 64'(j.exp_bus));
    check({j.name, "/done_cycle"}, 64'(done_t), 64'(j.exp_done));
    check({j.name, "/lane_mode"}, 64'(mode_bad), 64'd0);
    check({j.name, "/busy"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/i_bus"}, 64'(i_bus != '0), 64'd0);
    check({tag, "/w_bus"}, 64'(w_bus != '0), 64'd0);
    check({tag, "/lane_clr"}, 64'(lane_clr), 64'd1);
    check({tag, "/lane_mode"}, 64'(lane_mode), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/done"}, 64'(done), 64'd0);
    check({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int hs, n_done, n_busy, n_ir;
    vec[0] = mk("single", 1,   1'b1, 8'b0000_0001, 1, 20'h10000, 20'h04000, 1'b0, 12,  1,   64'h40000);
    vec[1] = mk("bubble", 4,   1'b0, 8'b0101_1001, 7, 20'h20000, 20'h08000, 1'b0, 18,  4,   64'h400000);
    vec[2] = mk("zero",   0,   1'b0, 8'b0000_0000, 0, 20'h10000, 20'h10000, 1'b0, 10,  0,   64'h0);
    vec[3] = mk("reject", 2,   1'b1, 8'b0000_0000, 0, 20'h30000, 20'h10000, 1'b1, 13,  2,   64'h600000);
    vec[4] = mk("maxlen", 255, 1'b1, 8'b0000_0000, 0, 20'h10000, 20'h00010, 1'b0, 266, 255, 64'hFF00);

    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_mode = 1'b0;
    in_valid = 1'b0; in_i = '0; in_w = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("por/lane_clr_release", 64'(lane_clr), 64'd0);

    // Jobs run back to back: each next command is taken in the idle cycle after done.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run_job(vec[i]);
    end

    // Reset after 2 of 5 beats.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = LW'(5); cmd_mode = 1'b1;
    in_valid = 1'b1; in_i = splat(20'h00001); in_w = splat(20'h00001);
    hs = 0;
    for (int c = 0; c < 50 && hs < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (in_ready) hs++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst/beats_before", 64'(hs), 64'd2);
    check("midrst/busy_before", 64'(busy), 64'd1);
    check("midrst/mode_before", 64'(lane_mode), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    n_done = 0; n_busy = 0; n_ir = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
      if (in_ready) n_ir++;
    end
    in_valid = 1'b0;
    check("midrst/no_done", 64'(n_done), 64'd0);
    check("midrst/no_busy", 64'(n_busy), 64'd0);
    check("midrst/no_in_ready", 64'(n_ir), 64'd0);
    check("midrst/cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst/lane_clr", 64'(lane_clr), 64'd0);

    @(negedge clk);
    run_job(vec[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_lane_feeder.md
# mac_lane_feeder

Front-end sequencer directly upstream of the 16-wide MAC lane. It accepts a job command (vector count, activation mode) and streams 16-element activation/weight vector pairs from a valid/ready source onto the lane's `i_*`/`w_*` inputs. It clears the lane's pipeline and accumulator before each job and drives the lane's `mode`. It pulses `done` in the exact cycle the lane's `f` output carries the finished dot-product result.

## Interface
- `IL`, default 4: integer bits per fixed-point element (matches lane).
- `FL`, default 16: fractional bits per element (matches lane).
- `LW`, default 8: width of the job-length field.
- `CLR_CYC`, default 2: cycles `lane_clr` is held at job start; must be ≥1.
- `LANE_LAT`, default 8: cycles from a vector pair appearing on `i_bus`/`w_bus` to its contribution appearing on lane `f`; set to match the instantiated lane.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `cmd_valid`  in  1  job command valid.
- `cmd_ready`  out  1  feeder can accept a command.
- `cmd_len`  in  LW  number of vector pairs in the job; 0 is legal.
- `cmd_mode`  in  1  activation select forwarded to the lane (1 = ReLU, 0 = SiLU).
- `in_valid`  in  1  vector pair valid.
- `in_ready`  out  1  feeder accepts a vector pair this cycle.
- `in_i`  in  16*(IL+FL)  activation vector; element k at bits [k*(IL+FL) +: IL+FL].
- `in_w`  in  16*(IL+FL)  weight vector; same packing as `in_i`.
- `i_bus`  out  16*(IL+FL)  to lane `i_0..i_15` (element k to `i_k`).
- `w_bus`  out  16*(IL+FL)  to lane `w_0..w_15`.
- `lane_clr`  out  1  to the lane's synchronous active-high `reset`.
- `lane_mode`  out  1  to lane `mode`.
- `busy`  out  1  job in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse; lane `f` holds the job result in this cycle.

## Operation
- FSM has five states: IDLE, CLEAR, STREAM, DRAIN, DONE. All outputs except `cmd_ready`/`in_ready` are registered.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: latch `cmd_len` into a beat counter, latch `cmd_mode` into `lane_mode`, go to CLEAR.
- **CLEAR**
  - `lane_clr` = 1 for exactly `CLR_CYC` cycles; buses = 0.
  - Then go to STREAM. If the latched length is 0, go to DRAIN instead.
- **STREAM**
  - `in_ready` = 1.
  - Each handshake (`in_valid && in_ready`) registers `in_i`/`in_w` onto `i_bus`/`w_bus` for exactly one cycle and decrements the remaining count.
  - Cycles without a handshake drive all-zero buses. Zero products add nothing to the lane accumulator, so source bubbles are harmless.
  - After the handshake that consumes the last beat, go to DRAIN.
- **DRAIN**
  - Buses = 0.
  - A drain counter guarantees `done` fires exactly `LANE_LAT` cycles after the last beat's bus cycle.
  - For a zero-length job, `done` fires `LANE_LAT` cycles after the last CLEAR cycle.
- **DONE**
  - `done` = 1 for one cycle, then return to IDLE.
- `lane_mode` holds its latched value from command accept until the next accept, including while in IDLE, so lane `f` stays stable after `done`.
- `cmd_ready` = 0 and `in_ready` = 0 outside their respective states. Commands and vectors presented at other times are ignored, not queued.
- Data passes through unmodified. No arithmetic is performed; width is preserved bit-for-bit.

## Timing
- **Reset values:** `i_bus` = 0, `w_bus` = 0, `lane_clr` = 1, `lane_mode` = 0, `busy` = 0, `done` = 0, state IDLE.
  - The first clock edge after reset deassertion drives `lane_clr` to 0.
  - `cmd_ready` = 1 and `in_ready` = 0 while in reset.
- **Command accept** at edge E: `busy` and `lane_clr` are high from cycle E+1 through E+`CLR_CYC`.
  - STREAM is entered at cycle E+`CLR_CYC`+1; `in_ready` is first high in that cycle.
- **Beat path:** a handshake at edge H puts the data on the buses in cycle H+1 only.
- **Completion:** if the last beat is on the bus in cycle L, then `done` is high in cycle L+`LANE_LAT`, `busy` is low from L+`LANE_LAT`+1, and `cmd_ready` is high in that same cycle.
- **Back-to-back jobs:** the minimum gap from `done` to the next job's `lane_clr` is 1 cycle (the IDLE accept cycle).
- **Reset mid-job:** asynchronously returns to IDLE with the reset values above.
  - Any partially accepted beats are discarded.
  - `lane_clr` = 1 during reset also flushes the lane.
- **Counter boundaries:**
  - `cmd_len` = 2^LW−1 completes without wrap.
  - The beat counter never underflows; an extra `in_valid` after the last beat sees `in_ready` = 0.

## Test plan
- **Single beat:** `cmd_len`=1, mode=1; send all `in_i`=0x10000 (1.0) and all `in_w`=0x04000 (0.25).
  - `lane_clr` is high exactly 2 cycles.
  - The buses carry the data for exactly 1 cycle.
  - `done` is high exactly 8 cycles later.
  - Lane `f` = 0x40000 (4.0) in the `done` cycle.
- **Bubbled stream:** `cmd_len`=4; `in_valid` toggles 1,0,0,1,1,0,1.
  - Exactly 4 nonzero bus cycles, with zero buses in between.
  - `done` = last data bus cycle + 8.
- **Zero length:** `cmd_len`=0, mode=0.
  - `in_ready` is never asserted.
  - `done` comes 8 cycles after the last `lane_clr` cycle.
  - `lane_mode`=0 throughout.
- **Busy rejection:** assert `cmd_valid` with `cmd_len`=3 during STREAM.
  - `cmd_ready`=0 and the command is ignored.
  - The current job completes with its original count.
  - A new command accepted in the IDLE cycle after `done` starts a fresh clear.
- **Reset mid-stream:** pull `reset` low after 2 of 5 beats.
  - All outputs take their reset values immediately, with `lane_clr`=1.
  - After release the FSM is in IDLE with `cmd_ready`=1, and no `done` is ever produced for the aborted job.
- **Max length:** `cmd_len`=255 with continuous `in_valid`.
  - Exactly 255 handshakes, then `in_ready` drops.
  - `done` = cycle of beat 255 on the bus + 8.
